pic_inta_sequencer: RTL and testbench

- Clocked controller that sequences the two-pulse 8086-mode interrupt-acknowledge cycle for the 8259 PIC.
- On the first int_ack pulse it freezes IRR, captures the winning request from the priority resolver and sets the ISR bit.
- On the second pulse it drives the vector onto the data bus.
- Also handles master/slave cascade addressing, spurious IR7, automatic EOI and a stuck-acknowledge timeout.
- Sits between control logic, priority resolver, ISR and the data bus output mux.

---
 rtl/pic_inta_sequencer.sv | 123 ++++++++++++
 tb/tb_pic_inta_sequencer.sv | 133 +++++++++++++
 2 files changed

// File: rtl/pic_inta_sequencer.sv
// pic_inta_sequencer: 8086-mode two-pulse INTA sequencer with cascade, AEOI, spurious IR7 and timeout
module pic_inta_sequencer #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       int_ack,
  input  logic [7:0] interrupt_vector,
  input  logic [4:0] vector_base,
  input  logic       aeoi_mode,
  input  logic       sngl,
  input  logic       SP_EN,
  input  logic [7:0] cascade_config,
  input  logic [2:0] cascade_i,
  output logic [2:0] cascade_o,
  output logic       freeze,
  output logic [7:0] isr_set,
  output logic [7:0] eoi_auto,
  output logic       out_control_logic_data,
  output logic [7:0] control_logic_data,
  output logic       ack_timeout_err
);
  typedef enum logic [1:0] {IDLE, ACK1, WAIT2, ACK2} state_t;
  state_t state, state_n;
  logic [2:0] sync;
  logic ack_rise, ack_fall, timeout;
  logic [7:0] cap, cap_n, new_cap, cnt, cnt_n, isr_n, eoi_n, data_n;
  logic [2:0] idx, idx_n, new_idx, cas_n;
  logic spurious, spur_n, drive, drive_n, sel, sel_n, freeze_n, oe_n, err_n;
  assign ack_rise = sync[1] & ~sync[2];
  assign ack_fall = ~sync[1] & sync[2];
  assign new_cap = |interrupt_vector ? interrupt_vector : 8'h80;
  assign timeout = (state != IDLE) && (cnt == 8'(ACK_TIMEOUT - 1));
  always_comb begin
    new_idx = 3'd0;
    for (int i = 0; i < 8; i++) if (new_cap[i]) new_idx = 3'(i);
  end
  always_comb begin
    state_n = state;
    cap_n = cap;
    idx_n = idx;
    spur_n = spurious;
    drive_n = drive;
    sel_n = sel;
    cnt_n = (state == IDLE) ? 8'd0 : cnt + 8'd1;
    freeze_n = freeze;
    isr_n = 8'd0;
    eoi_n = 8'd0;
    oe_n = out_control_logic_data;
    data_n = control_logic_data;
    cas_n = cascade_o;
    err_n = 1'b0;
    if (state == IDLE && ack_rise) begin
      state_n = ACK1;
      cnt_n = 8'd0;
      freeze_n = 1'b1;
      cap_n = new_cap;
      idx_n = new_idx;
      spur_n = ~|interrupt_vector;
      sel_n = SP_EN | (cascade_i == cascade_config[2:0]);
      drive_n = SP_EN ? (sngl | ~cascade_config[new_idx]) : sel_n;
      cas_n = (SP_EN & ~sngl & cascade_config[new_idx]) ? new_idx : 3'd0;
      isr_n = (sel_n & ~spur_n) ? new_cap : 8'd0;
    end else if (state == ACK1 && ack_fall) begin
      state_n = WAIT2;
      cnt_n = 8'd0;
    end else if (state == WAIT2 && ack_rise) begin
      state_n = ACK2;
      cnt_n = 8'd0;
      oe_n = drive;
      data_n = drive ? {vector_base, idx} : 8'd0;
    end else if ((state == ACK2 && ack_fall) || timeout) begin
      // Normal completion and abort share the teardown; only completion may auto-EOI
      state_n = IDLE;
      cnt_n = 8'd0;
      oe_n = 1'b0;
      data_n = 8'd0;
      freeze_n = 1'b0;
      cas_n = 3'd0;
      eoi_n = (!timeout && aeoi_mode && !spurious && sel) ? cap : 8'd0;
      err_n = timeout && !(state == ACK2 && ack_fall);
      cap_n = 8'd0;
      spur_n = 1'b0;
      drive_n = 1'b0;
      sel_n = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sync <= 3'd0;
      cap <= 8'd0;
      idx <= 3'd0;
      spurious <= 1'b0;
      drive <= 1'b0;
      sel <= 1'b0;
      cnt <= 8'd0;
      freeze <= 1'b0;
      isr_set <= 8'd0;
      eoi_auto <= 8'd0;
      out_control_logic_data <= 1'b0;
      control_logic_data <= 8'd0;
      cascade_o <= 3'd0;
      ack_timeout_err <= 1'b0;
    end else begin
      state <= state_n;
      sync <= {sync[1:0], int_ack};
      cap <= cap_n;
      idx <= idx_n;
      spurious <= spur_n;
      drive <= drive_n;
      sel <= sel_n;
      cnt <= cnt_n;
      freeze <= freeze_n;
      isr_set <= isr_n;
      eoi_auto <= eoi_n;
      out_control_logic_data <= oe_n;
      control_logic_data <= data_n;
      cascade_o <= cas_n;
      ack_timeout_err <= err_n;
    end
  end
endmodule

// File: tb/tb_pic_inta_sequencer.sv
// tb_pic_inta_sequencer: directed checks of the INTA sequencer with ACK_TIMEOUT=16
module tb_pic_inta_sequencer;
  logic clk = 1'b0, reset = 1'b1, int_ack = 1'b0;
  logic [7:0] interrupt_vector = 8'h00, cascade_config = 8'h00;
  logic [4:0] vector_base = 5'b01000;
  logic aeoi_mode = 1'b0, sngl = 1'b1, SP_EN = 1'b1;
  logic [2:0] cascade_i = 3'd0, cascade_o;
  logic freeze, out_control_logic_data, ack_timeout_err;
  logic [7:0] isr_set, eoi_auto, control_logic_data;
  int n_chk = 0, n_fail = 0;
  pic_inta_sequencer #(.ACK_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .int_ack(int_ack), .interrupt_vector(interrupt_vector),
    .vector_base(vector_base), .aeoi_mode(aeoi_mode), .sngl(sngl), .SP_EN(SP_EN),
    .cascade_config(cascade_config), .cascade_i(cascade_i), .cascade_o(cascade_o),
    .freeze(freeze), .isr_set(isr_set), .eoi_auto(eoi_auto),
    .out_control_logic_data(out_control_logic_data), .control_logic_data(control_logic_data),
    .ack_timeout_err(ack_timeout_err)
  );
  always #5 clk = ~clk;
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  // Two full INTA pulses; each pin edge takes effect on the third clock edge
  task automatic run_cycle(input string t, input logic [7:0] e_isr, input logic [7:0] e_data,
                           input logic e_oe, input logic [7:0] e_eoi, input logic [2:0] e_cas);
    int_ack = 1'b1;
    step(3);
    chk({t, " isr_set"}, isr_set, e_isr);
    chk({t, " freeze1"}, {7'd0, freeze}, 8'd1);
    chk({t, " cas1"}, {5'd0, cascade_o}, {5'd0, e_cas});
    step(1);
    chk({t, " isr_pulse"}, isr_set, 8'h00);
    int_ack = 1'b0;
    step(3);
    chk({t, " freeze_wait2"}, {7'd0, freeze}, 8'd1);
    chk({t, " oe_wait2"}, {7'd0, out_control_logic_data}, 8'd0);
    int_ack = 1'b1;
    step(3);
    chk({t, " oe_ack2"}, {7'd0, out_control_logic_data}, {7'd0, e_oe});
    chk({t, " data_ack2"}, control_logic_data, e_data);
    chk({t, " cas2"}, {5'd0, cascade_o}, {5'd0, e_cas});
    int_ack = 1'b0;
    step(2);
    chk({t, " freeze_pre_fall"}, {7'd0, freeze}, 8'd1);
    chk({t, " eoi_pre_fall"}, eoi_auto, 8'h00);
    step(1);
    chk({t, " oe_end"}, {7'd0, out_control_logic_data}, 8'd0);
    chk({t, " data_end"}, control_logic_data, 8'h00);
    chk({t, " freeze_end"}, {7'd0, freeze}, 8'd0);
    chk({t, " cas_end"}, {5'd0, cascade_o}, 8'd0);
    chk({t, " eoi_auto"}, eoi_auto, e_eoi);
    step(1);
    chk({t, " eoi_pulse"}, eoi_auto, 8'h00);
    step(2);
  endtask
  initial begin
    step(2);
    chk("rst freeze", {7'd0, freeze}, 8'd0);
    chk("rst isr", isr_set, 8'h00);
    chk("rst oe", {7'd0, out_control_logic_data}, 8'd0);
    chk("rst data", control_logic_data, 8'h00);
    chk("rst cas", {5'd0, cascade_o}, 8'd0);
    chk("rst err", {7'd0, ack_timeout_err}, 8'd0);
    reset = 1'b0;
    step(2);
    interrupt_vector = 8'h08;
    run_cycle("A", 8'h08, 8'h43, 1'b1, 8'h00, 3'd0);
    aeoi_mode = 1'b1;
    run_cycle("B", 8'h08, 8'h43, 1'b1, 8'h08, 3'd0);
    interrupt_vector = 8'h00;
    run_cycle("C", 8'h00, 8'h47, 1'b1, 8'h00, 3'd0);
    aeoi_mode = 1'b0;
    sngl = 1'b0;
    cascade_config = 8'h04;
    interrupt_vector = 8'h04;
    run_cycle("D", 8'h04, 8'h00, 1'b0, 8'h00, 3'd2);
    SP_EN = 1'b0;
    cascade_config = 8'h02;
    cascade_i = 3'd2;
    interrupt_vector = 8'h08;
    run_cycle("E", 8'h08, 8'h43, 1'b1, 8'h00, 3'd0);
    aeoi_mode = 1'b1;
    cascade_i = 3'd5;
    run_cycle("F", 8'h00, 8'h00, 1'b0, 8'h00, 3'd0);
    aeoi_mode = 1'b0;
    SP_EN = 1'b1;
    sngl = 1'b1;
    cascade_config = 8'h00;
    cascade_i = 3'd0;
    int_ack = 1'b1;
    step(3);
    chk("G isr_set", isr_set, 8'h08);
    int_ack = 1'b0;
    step(3);
    step(15);
    chk("G err_early", {7'd0, ack_timeout_err}, 8'd0);
    chk("G freeze_held", {7'd0, freeze}, 8'd1);
    step(1);
    chk("G err", {7'd0, ack_timeout_err}, 8'd1);
    chk("G freeze_off", {7'd0, freeze}, 8'd0);
    chk("G eoi_none", eoi_auto, 8'h00);
    step(1);
    chk("G err_pulse", {7'd0, ack_timeout_err}, 8'd0);
    step(2);
    int_ack = 1'b1;
    step(3);
    int_ack = 1'b0;
    step(3);
    int_ack = 1'b1;
    step(3);
    chk("H oe_ack2", {7'd0, out_control_logic_data}, 8'd1);
    #2 reset = 1'b1;
    #1;
    chk("H async oe", {7'd0, out_control_logic_data}, 8'd0);
    chk("H async data", control_logic_data, 8'h00);
    chk("H async freeze", {7'd0, freeze}, 8'd0);
    int_ack = 1'b0;
    step(2);
    reset = 1'b0;
    step(2);
    run_cycle("I", 8'h08, 8'h43, 1'b1, 8'h00, 3'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
